// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared event kinds, direction encoding and event record widths
package pingpong_pkg;
    localparam logic [1:0] EV_TOP    = 2'b01;
    localparam logic [1:0] EV_BOTTOM = 2'b10;
    localparam logic [0:0] RISING    = 1'b0;
    localparam logic [0:0] FALLING   = 1'b1;
    localparam int EV_KIND_W  = 2;
    localparam int EV_VALUE_W = 32;
    localparam int EV_INDEX_W = 16;
    localparam int EV_TIME_W  = 32;
    localparam int EV_BASE_W  = EV_KIND_W + EV_VALUE_W + EV_INDEX_W;
endpackage

// File: rtl/pingpong_event_fifo.sv
// pingpong_event_fifo: synchronous FIFO with registered head, valid/ready pop and push-accept
module pingpong_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             push_accept,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign head_valid  = count != '0;
    assign full        = count == (AW + 1)'(DEPTH);
    assign do_pop      = head_valid && pop_ready;
    assign push_accept = !full || do_pop;
    assign do_push     = push && push_accept;
    assign head_data   = head_valid ? mem[rd_ptr] : '0;
    // storage: when full with a pop, the freed head slot becomes the new tail
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/pingpong_bounce_monitor.sv
// pingpong_bounce_monitor: detects threshold reversals and queues events; PINGPONG_MON_TIMESTAMP_EN adds cycle stamps
module pingpong_bounce_monitor
    import pingpong_pkg::*;
#(
    parameter logic signed [31:0] MAX_THRESHOLD = 32'sd100,
    parameter logic signed [31:0] MIN_THRESHOLD = 32'sd0,
    parameter int                 FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] sample_value,
    input  logic               sample_en,
    output logic               event_valid,
    input  logic               event_ready,
    output logic [1:0]         event_kind,
    output logic [31:0]        event_value,
    output logic [15:0]        event_index,
    output logic [31:0]        event_time,
    output logic               direction,
    output logic [15:0]        bounce_count,
    output logic [7:0]         drop_count,
    output logic               overflow
);
`ifdef PINGPONG_MON_TIMESTAMP_EN
    localparam int REC_W = EV_BASE_W + EV_TIME_W;
    logic [31:0] cycle_cnt;
`else
    localparam int REC_W = EV_BASE_W;
`endif
    logic hit_top, hit_bot, create, pop, push_accept, fifo_full, drop;
    logic [15:0] next_count;
    logic [REC_W-1:0] push_rec, head_rec;
    assign hit_top    = sample_en && direction == RISING && sample_value > MAX_THRESHOLD;
    assign hit_bot    = sample_en && direction == FALLING && sample_value < MIN_THRESHOLD;
    assign create     = hit_top || hit_bot;
    assign next_count = bounce_count + 16'd1;
    assign pop        = event_valid && event_ready;
    assign drop       = create && !push_accept && fifo_full;
`ifdef PINGPONG_MON_TIMESTAMP_EN
    assign push_rec   = {hit_top ? EV_TOP : EV_BOTTOM, sample_value, next_count, cycle_cnt};
    assign event_time = head_rec[EV_TIME_W-1:0];
    // free-running stamp source
    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= '0;
        else cycle_cnt <= cycle_cnt + 32'd1;
    end
`else
    assign push_rec   = {hit_top ? EV_TOP : EV_BOTTOM, sample_value, next_count};
    assign event_time = '0;
`endif
    assign event_kind  = head_rec[REC_W-1 -: EV_KIND_W];
    assign event_value = head_rec[REC_W-EV_KIND_W-1 -: EV_VALUE_W];
    assign event_index = head_rec[REC_W-EV_KIND_W-EV_VALUE_W-1 -: EV_INDEX_W];

    pingpong_event_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (create),
        .push_data   (push_rec),
        .pop_ready   (event_ready),
        .head_valid  (event_valid),
        .head_data   (head_rec),
        .push_accept (push_accept),
        .full        (fifo_full)
    );

    // direction FSM, bounce counter and drop accounting; dropped events still advance the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            direction    <= RISING;
            bounce_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else if (create) begin
            direction    <= ~direction;
            bounce_count <= next_count;
            if (drop) begin
                drop_count <= (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
                overflow   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pingpong_bounce_monitor.sv
// tb_pingpong_bounce_monitor: table vectors, corner sequences and randomized run against a queue model
module tb_pingpong_bounce_monitor;
    localparam int MAXT = 100;
    localparam int MINT = 0;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, sample_en, event_ready;
    logic signed [31:0] sample_value;
    logic event_valid, direction, overflow;
    logic [1:0] event_kind;
    logic [31:0] event_value, event_time;
    logic [15:0] event_index, bounce_count;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    pingpong_bounce_monitor #(
        .MAX_THRESHOLD(MAXT), .MIN_THRESHOLD(MINT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .sample_value(sample_value), .sample_en(sample_en),
        .event_valid(event_valid), .event_ready(event_ready), .event_kind(event_kind),
        .event_value(event_value), .event_index(event_index), .event_time(event_time),
        .direction(direction), .bounce_count(bounce_count), .drop_count(drop_count),
        .overflow(overflow)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] value;
        logic [15:0] index;
        logic [31:0] stamp;
    } ev_t;

    typedef struct {
        logic        en;
        logic [31:0] val;
        logic        rdy;
        logic        ev;
        logic [1:0]  kind;
        logic [31:0] value;
        logic [15:0] idx;
        logic        dir;
        logic [15:0] bc;
    } vec_t;

    ev_t q[$];
    logic m_dir;
    logic [15:0] m_bc;
    int m_drop;
    logic m_ovf;
    logic [31:0] m_cyc;
    int tests = 0;
    int fails = 0;
    vec_t vt[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference behaviour applied at one clock edge
    task automatic model_edge(input logic en, input logic signed [31:0] val, input logic rdy, input logic r);
        logic pop, top, bot;
        ev_t e;
        if (r) begin
            q.delete();
            m_dir = 0; m_bc = 0; m_drop = 0; m_ovf = 0; m_cyc = 0;
            return;
        end
        pop = q.size() > 0 && rdy;
        top = en && !m_dir && val > MAXT;
        bot = en && m_dir && val < MINT;
        if (pop) void'(q.pop_front());
        if (top || bot) begin
            m_bc = m_bc + 16'd1;
            m_dir = ~m_dir;
            e.kind = top ? 2'b01 : 2'b10;
            e.value = val;
            e.index = m_bc;
            e.stamp = m_cyc;
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                if (m_drop < 255) m_drop++;
                m_ovf = 1;
            end
        end
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic check_model(input string tag);
        ev_t h;
        h = '{kind: 2'b00, value: 32'h0, index: 16'h0, stamp: 32'h0};
        if (q.size() > 0) h = q[0];
        chk({tag, ".valid"}, event_valid, q.size() > 0);
        chk({tag, ".kind"}, event_kind, h.kind);
        chk({tag, ".value"}, event_value, h.value);
        chk({tag, ".index"}, event_index, h.index);
`ifdef PINGPONG_MON_TIMESTAMP_EN
        chk({tag, ".time"}, event_time, h.stamp);
`else
        chk({tag, ".time"}, event_time, 32'h0);
`endif
        chk({tag, ".dir"}, direction, m_dir);
        chk({tag, ".bc"}, bounce_count, m_bc);
        chk({tag, ".drop"}, drop_count, m_drop);
        chk({tag, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic step(input logic en, input logic signed [31:0] val, input logic rdy, input string tag);
        rst = 0; sample_en = en; sample_value = val; event_ready = rdy;
        @(posedge clk);
        model_edge(en, val, rdy, 1'b0);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1; sample_en = 0; sample_value = 0; event_ready = 0;
        @(posedge clk);
        model_edge(1'b0, 0, 1'b0, 1'b1);
        #1;
        rst = 0;
        check_model(tag);
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'd5,   1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd0};
        vt[1]  = '{1'b1, 32'd15,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd0};
        vt[2]  = '{1'b1, 32'd17,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd0};
        vt[3]  = '{1'b1, 32'd20,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd0};
        vt[4]  = '{1'b1, 32'd51,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd0};
        vt[5]  = '{1'b1, 32'd101, 1'b0, 1'b1, 2'b01, 32'h65, 16'd1, 1'b1, 16'd1};
        vt[6]  = '{1'b0, 32'd0,   1'b1, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd1};
        vt[7]  = '{1'b1, 32'd31,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd1};
        vt[8]  = '{1'b1, 32'd23,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd1};
        vt[9]  = '{1'b1, 32'd20,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd1};
        vt[10] = '{1'b1, 32'd11,  1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd1};
        vt[11] = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b10, 32'hFFFFFFFF, 16'd2, 1'b0, 16'd2};
        vt[12] = '{1'b0, 32'd0,   1'b1, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd2};
        vt[13] = '{1'b1, 32'hFFFFFFFB, 1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd2};
        vt[14] = '{1'b1, 32'd101, 1'b1, 1'b1, 2'b01, 32'h65, 16'd3, 1'b1, 16'd3};
        vt[15] = '{1'b1, 32'd150, 1'b0, 1'b1, 2'b01, 32'h65, 16'd3, 1'b1, 16'd3};
        vt[16] = '{1'b0, 32'd0,   1'b1, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd3};
        vt[17] = '{1'b0, 32'hFFFFFFCE, 1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd3};
        vt[18] = '{1'b1, 32'd0,   1'b0, 1'b0, 2'b00, 32'd0, 16'd0, 1'b1, 16'd3};
        vt[19] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b10, 32'hFFFFFFFF, 16'd4, 1'b0, 16'd4};
        vt[20] = '{1'b1, 32'd100, 1'b1, 1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 16'd4};

        do_reset("reset0");
        chk("reset.valid", event_valid, 0);
        chk("reset.bc", bounce_count, 0);

        for (int i = 0; i < 21; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vt[i].en, vt[i].val, vt[i].rdy, t);
            chk({t, ".x_valid"}, event_valid, vt[i].ev);
            chk({t, ".x_kind"}, event_kind, vt[i].kind);
            chk({t, ".x_value"}, event_value, vt[i].value);
            chk({t, ".x_index"}, event_index, vt[i].idx);
            chk({t, ".x_dir"}, direction, vt[i].dir);
            chk({t, ".x_bc"}, bounce_count, vt[i].bc);
        end

        do_reset("ovf.reset");
        for (int i = 0; i < 5; i++) step(1'b1, (i % 2 == 0) ? 101 : -1, 1'b0, "ovf.fill");
        chk("ovf.drop", drop_count, 1);
        chk("ovf.flag", overflow, 1);
        chk("ovf.bc", bounce_count, 5);
        chk("ovf.dir", direction, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 150, 1'b0, "ovf.stall");
            chk("ovf.stall_index", event_index, 1);
            chk("ovf.stall_value", event_value, 101);
            chk("ovf.stall_kind", event_kind, 2'b01);
        end
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf.drain_index%0d", i), event_index, i);
            step(1'b0, 0, 1'b1, "ovf.drain");
        end
        chk("ovf.empty", event_valid, 0);

        do_reset("full.reset");
        for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? 101 : -1, 1'b0, "full.fill");
        step(1'b1, 101, 1'b1, "full.pushpop");
        chk("full.drop", drop_count, 0);
        chk("full.ovf", overflow, 0);
        chk("full.head", event_index, 2);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("full.drain_index%0d", i), event_index, i);
            chk("full.drain_valid", event_valid, 1);
            step(1'b0, 0, 1'b1, "full.drain");
        end
        chk("full.empty", event_valid, 0);

        do_reset("mid.reset0");
        for (int i = 0; i < 3; i++) step(1'b1, (i % 2 == 0) ? 101 : -1, 1'b0, "mid.fill");
        do_reset("mid.reset");
        chk("mid.valid", event_valid, 0);
        chk("mid.bc", bounce_count, 0);
        chk("mid.dir", direction, 0);
        step(1'b1, 101, 1'b0, "mid.after");
        chk("mid.kind", event_kind, 2'b01);
        chk("mid.index", event_index, 1);

        for (int i = 0; i < 600; i++) begin
            logic signed [31:0] v;
            case ($urandom_range(0, 5))
                0: v = $urandom;
                1: v = 101;
                2: v = 100;
                3: v = -1;
                4: v = 0;
                default: v = $urandom_range(0, 100);
            endcase
            if ($urandom_range(0, 149) == 0) do_reset("rand.reset");
            else step($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pingpong_bounce_monitor.md
Name: pingpong_bounce_monitor

Overview:
Downstream consumer of the pingpong accumulator. Samples the running register value (curr_reg_value) and detects direction reversals: a crossing above MAX_THRESHOLD or below MIN_THRESHOLD. Each reversal is recorded as an event in a small FIFO, drained by a valid/ready consumer such as a debug/UART logger. Also keeps a bounce counter and a drop counter.

Parameters:
MAX_THRESHOLD, 100, signed 32-bit upper threshold; must match the accumulator.
MIN_THRESHOLD, 0, signed 32-bit lower threshold; must match the accumulator.
FIFO_DEPTH, 4, number of event entries; power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
sample_value  in  32  signed accumulator value, connected to curr_reg_value
sample_en  in  1  sample_value is valid this cycle
event_valid  out  1  FIFO head holds an event
event_ready  in  1  consumer accepts the head event
event_kind  out  2  head event kind: 01 = TOP, 10 = BOTTOM
event_value  out  32  sample that caused the event
event_index  out  16  bounce_count value at event creation (1-based)
event_time  out  32  cycle stamp (see Optional Feature)
direction  out  1  0 = RISING, 1 = FALLING
bounce_count  out  16  total detected reversals
drop_count  out  8  events lost because the FIFO was full
overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset: FSM = RISING; FIFO empty; all outputs 0, including event_valid, direction, counters, overflow and event_* outputs. Reset mid-operation discards pending events; event_valid is 0 in the cycle after rst is sampled high.
- All comparisons are signed 32-bit. Crossings use strict > MAX and < MIN.
- FSM has two states:
  - RISING: on sample_en with sample_value > MAX_THRESHOLD, create a TOP event and go to FALLING.
  - FALLING: on sample_en with sample_value < MIN_THRESHOLD, create a BOTTOM event and go to RISING.
  - Otherwise hold state. A value above MAX while FALLING, or below MIN while RISING, creates no event.
- Samples are ignored when sample_en = 0.
- Event creation:
  - bounce_count increments, wrapping at 16'hFFFF to 0.
  - event_index = the new bounce_count.
  - direction updates in the same edge.
- Latency: a crossing sample at edge N is visible at the FIFO head (event_valid = 1) after edge N when the FIFO was empty. Head outputs are registered; no combinational path from sample_value to event_*.
- Handshake:
  - Pop on event_valid && event_ready.
  - event_* hold stable while event_valid = 1 and event_ready = 0.
  - event_ready while empty has no effect.
- FIFO full:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped, drop_count saturates at 255, and overflow is set (cleared only by rst).
  - The FSM and bounce_count still advance on a dropped event.
- Simultaneous push and pop on an empty FIFO is impossible because the head is registered. Push and pop at count = 1 leaves count at 1 with the new head.
- Write and read pointers are log2(FIFO_DEPTH) bits and wrap naturally.

Optional Feature:
PINGPONG_MON_TIMESTAMP_EN
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) is stored with each event and driven on event_time.
- Undefined: no counter and no storage; event_time is tied to 0. The port list is identical in both builds.

Decomposition:
- Package pingpong_pkg:
  - event kind constants EV_TOP = 2'b01, EV_BOTTOM = 2'b10
  - direction state encoding: RISING = 0, FALLING = 1
  - event record width constants
- One sub-module: pingpong_event_fifo, a synchronous FIFO with parameterized width/depth, valid/ready pop, a push-accept output and a full flag. The monitor holds the FSM, counters and drop logic.

Test Plan:
- MAX = 100, MIN = 0. Samples 5, 15, 17, 20, 51, 101 -> a single TOP event: value 101 (0x65), index 1; direction = 1; bounce_count = 1.
- Continue with 31, 23, 20, 11, -1 -> BOTTOM event: value 0xFFFFFFFF, index 2; direction = 0.
- While FALLING, sample 150 -> no event. While RISING, sample -5 -> no event. bounce_count is unchanged in both cases.
- event_ready = 0, force 5 alternating crossings with FIFO_DEPTH = 4 -> 4 events held, drop_count = 1, overflow = 1, bounce_count = 5. Then drain -> indices 1, 2, 3, 4 in order, and event_* stay stable while stalled.
- FIFO full, event_ready = 1 on the same cycle as a new crossing -> the push is accepted, drop_count stays 0, and the FIFO stays full with the new event at the tail.
- Assert rst for one cycle with 3 events queued -> the next cycle shows event_valid = 0, counters = 0, direction = 0. A subsequent sample of 101 yields a TOP event with index 1.
